// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: data-path defaults, branch
// condition encodings and the condition-code record.
package alu_result_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int RD_W_DEF   = 3;
    localparam int DEPTH_DEF  = 2;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_EQ     = 3'd1,
        COND_NE     = 3'd2,
        COND_LT     = 3'd3,
        COND_GE     = 3'd4,
        COND_MI     = 3'd5,
        COND_VS     = 3'd6,
        COND_NEVER  = 3'd7
    } cond_e;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } cc_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-side input and writeback-side output handshakes of the result stage.
interface alu_result_stage_if #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_z;
    logic              in_v;
    logic              in_n;
    logic [RD_W-1:0]   in_rd;
    logic              in_wen;
    logic              in_setcc;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_wen;

    // Environment side: drives ALU results and writeback acceptance.
    modport master (
        output in_valid, in_data, in_z, in_v, in_n, in_rd, in_wen, in_setcc,
        output out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_wen
    );

    // Stage side.
    modport slave (
        input  in_valid, in_data, in_z, in_v, in_n, in_rd, in_wen, in_setcc,
        input  out_ready,
        output in_ready, out_valid, out_data, out_rd, out_wen
    );
endinterface

// File: rtl/alu_result_stage_cond_eval.sv
// Branch condition evaluator: pure combinational decode of a condition
// select against a condition-code record; shared with the branch unit.
module cond_eval
    import alu_result_stage_pkg::*;
(
    input  cc_t        cc,
    input  logic [2:0] cond_sel,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond_sel))
            COND_ALWAYS: cond_true = 1'b1;
            COND_EQ:     cond_true = cc.z;
            COND_NE:     cond_true = ~cc.z;
            COND_LT:     cond_true = cc.n ^ cc.v;
            COND_GE:     cond_true = ~(cc.n ^ cc.v);
            COND_MI:     cond_true = cc.n;
            COND_VS:     cond_true = cc.v;
            COND_NEVER:  cond_true = 1'b0;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid FIFO toward writeback, architectural
// condition-code register and branch condition output.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
)(
    input  logic                clk,
    input  logic                rst_n,
    alu_result_stage_if.slave   bus,
    output logic                cc_z,
    output logic                cc_v,
    output logic                cc_n,
    input  logic [2:0]          cond_sel,
    output logic                cond_true
);

    localparam int         ENTRY_W = DATA_W + RD_W + 1;
    localparam logic [1:0] FULL    = 2'(DEPTH);

    logic [ENTRY_W-1:0] slot_reg [DEPTH];
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         count_reg;
    logic [1:0]         count_next;
    logic               in_ready_reg;
    cc_t                cc_reg;

    logic               out_valid;
    logic               accept;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic               cond_raw;

    assign out_valid = (count_reg != 2'd0);
    assign accept    = bus.in_valid & in_ready_reg;
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        count_next = count_reg;
        case ({accept, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // in_ready is registered from the next count so it never depends
    // combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_reg[i] <= '0;
            end
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            in_ready_reg <= 1'b0;
            cc_reg       <= '0;
        end else begin
            count_reg    <= count_next;
            in_ready_reg <= (count_next != FULL);
            if (accept) begin
                slot_reg[wr_ptr_reg] <= {bus.in_data, bus.in_rd, bus.in_wen};
                wr_ptr_reg           <= ~wr_ptr_reg;
                if (bus.in_setcc) begin
                    cc_reg <= '{z: bus.in_z, v: bus.in_v, n: bus.in_n};
                end
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    assign head = slot_reg[rd_ptr_reg];

    always_comb begin
        bus.out_data = '0;
        bus.out_rd   = '0;
        bus.out_wen  = 1'b0;
        if (out_valid) begin
            bus.out_data = head[ENTRY_W-1 -: DATA_W];
            bus.out_rd   = head[RD_W:1];
            bus.out_wen  = head[0];
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid;

    assign cc_z = cc_reg.z;
    assign cc_v = cc_reg.v;
    assign cc_n = cc_reg.n;

    cond_eval u_cond_eval (
        .cc        (cc_reg),
        .cond_sel  (cond_sel),
        .cond_true (cond_raw)
    );

    // While held in reset only the unconditional select reports true.
    assign cond_true = rst_n ? cond_raw : (cond_sel == COND_ALWAYS);

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed-vector bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

    logic       clk;
    logic       rst_n;
    logic       cc_z;
    logic       cc_v;
    logic       cc_n;
    logic [2:0] cond_sel;
    logic       cond_true;

    int n_compared;
    int n_mismatched;

    alu_result_stage_if #(.DATA_W(16), .RD_W(3)) bus ();

    alu_result_stage #(.DATA_W(16), .RD_W(3), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cc_z      (cc_z),
        .cc_v      (cc_v),
        .cc_n      (cc_n),
        .cond_sel  (cond_sel),
        .cond_true (cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_compared++;
        if (obs !== exp_val) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_val);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Let one rising edge pass with the current inputs, then settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic z, input logic ov,
                         input logic n, input logic [2:0] rd, input logic wen, input logic setcc);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_z     = z;
        bus.in_v     = ov;
        bus.in_n     = n;
        bus.in_rd    = rd;
        bus.in_wen   = wen;
        bus.in_setcc = setcc;
    endtask

    task automatic check_cond(input string tag, input logic [2:0] sel, input logic exp_val);
        cond_sel = sel;
        #1;
        chk(tag, 32'(cond_true), 32'(exp_val));
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        cond_sel     = 3'd0;
        bus.out_ready = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

        // Power-on reset
        step();
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_cc", 32'({cc_z, cc_v, cc_n}), 32'd0);
        check_cond("rst_cond_always", 3'd0, 1'b1);
        check_cond("rst_cond_ne", 3'd2, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("release_before_edge_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("release_after_edge_in_ready", 32'(bus.in_ready), 32'd1);

        // NAND-style result: negative, written back, sets CC
        drive(1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("nand_out_valid", 32'(bus.out_valid), 32'd1);
        chk("nand_out_data", 32'(bus.out_data), 32'hFFFE);
        chk("nand_out_rd", 32'(bus.out_rd), 32'd3);
        chk("nand_out_wen", 32'(bus.out_wen), 32'd1);
        chk("nand_cc", 32'({cc_z, cc_v, cc_n}), 32'b001);
        check_cond("nand_cond_mi", 3'd5, 1'b1);
        check_cond("nand_cond_eq", 3'd1, 1'b0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("nand_pop_out_valid", 32'(bus.out_valid), 32'd0);
        chk("nand_pop_out_data", 32'(bus.out_data), 32'd0);

        // Zero result
        drive(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("zero_out_valid", 32'(bus.out_valid), 32'd1);
        chk("zero_out_rd", 32'(bus.out_rd), 32'd5);
        chk("zero_cc", 32'({cc_z, cc_v, cc_n}), 32'b100);
        check_cond("zero_cond_eq", 3'd1, 1'b1);
        check_cond("zero_cond_ne", 3'd2, 1'b0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("zero_pop_out_valid", 32'(bus.out_valid), 32'd0);

        // Full / backpressure
        drive(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
        step();
        chk("full_first_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        step();
        chk("full_second_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_head", 32'(bus.out_data), 32'h1111);
        drive(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
        step();
        chk("full_third_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_third_head", 32'(bus.out_data), 32'h1111);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk("drain_head2", 32'(bus.out_data), 32'h2222);
        chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("drain_empty", 32'(bus.out_valid), 32'd0);
        chk("drain_empty_data", 32'(bus.out_data), 32'd0);

        // Streaming with simultaneous accept and pop at count=1
        bus.out_ready = 1'b0;
        drive(1'b1, 16'hA000, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0);
        step();
        chk("stream_first_head", 32'(bus.out_data), 32'hA000);
        bus.out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            drive(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0);
            step();
            chk($sformatf("stream_head_%0d", i), 32'(bus.out_data), 32'hA000 + 32'(i));
            chk($sformatf("stream_ready_%0d", i), 32'({bus.in_ready, bus.out_valid}), 32'b11);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        chk("stream_done_empty", 32'(bus.out_valid), 32'd0);

        // CC gating and LT/GE
        drive(1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1);
        step();
        chk("cc_set_011", 32'({cc_z, cc_v, cc_n}), 32'b011);
        check_cond("cc_lt", 3'd3, 1'b0);
        check_cond("cc_ge", 3'd4, 1'b1);
        check_cond("cc_vs", 3'd6, 1'b1);
        drive(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
        step();
        chk("cc_setcc0_unchanged", 32'({cc_z, cc_v, cc_n}), 32'b011);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 1'b1);
        step();
        chk("cc_novalid_unchanged", 32'({cc_z, cc_v, cc_n}), 32'b011);
        check_cond("cc_never", 3'd7, 1'b0);
        check_cond("cc_always", 3'd0, 1'b1);
        step();

        // Reset asserted with the FIFO full and CC non-zero
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h5555, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1);
        step();
        drive(1'b1, 16'h6666, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("midrst_full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_cc_before", 32'({cc_z, cc_v, cc_n}), 32'b110);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_data", 32'(bus.out_data), 32'd0);
        chk("midrst_cc", 32'({cc_z, cc_v, cc_n}), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check_cond("midrst_cond_ge", 3'd4, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        chk("midrst_release_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("midrst_after_edge_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_after_edge_out_valid", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage of ALU_16; captures each ALU result and its z/v/n flags.
- Buffers results in a 2-entry skid FIFO with a valid/ready handshake toward register-file writeback.
- Holds the architectural condition-code register (CC).
- Evaluates branch conditions from CC for the fetch/branch unit.

Parameters:
- DATA_W, 16, width of the ALU result and data path.
- RD_W, 3, destination register index width (8 GPRs).
- DEPTH, 2, FIFO entries; fixed at 2; other values are unsupported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU result valid this cycle.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  ALU_16 alu_out.
- in_z  in  1  ALU zero flag.
- in_v  in  1  ALU overflow flag.
- in_n  in  1  ALU sign flag.
- in_rd  in  RD_W  destination register.
- in_wen  in  1  result is written back.
- in_setcc  in  1  instruction updates CC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback accepts head.
- out_data  out  DATA_W  head result.
- out_rd  out  RD_W  head destination.
- out_wen  out  1  head write enable.
- cc_z, cc_v, cc_n  out  1 each  registered CC.
- cond_sel  in  3  branch condition select.
- cond_true  out  1  selected condition holds.

Behaviour:
- Reset, asynchronous assert: count=0, read/write pointers=0, CC=000, all storage cleared.
  - Outputs while in reset: in_ready=0, out_valid=0, out_data/out_rd/out_wen=0, cond_true = (cond_sel==0).
  - in_ready goes to 1 on the first clk edge after rst_n deasserts.
- Reset asserted mid-operation discards all FIFO entries and CC immediately. No partial writeback.
- Accept: in_valid & in_ready at an edge writes {in_data, in_rd, in_wen} to slot wr_ptr. wr_ptr then toggles (wraps 1->0).
- Pop: out_valid & out_ready at an edge; rd_ptr toggles.
- Ready/valid definitions:
  - in_ready = registered (count != 2). It has no combinational path from out_ready.
  - out_valid = (count != 0).
- Count update:
  - Accept only: +1.
  - Pop only: -1.
  - Both in the same cycle: unchanged. This is allowed at count=1.
  - At count=2 only a pop can occur.
- Empty output drive: when out_valid=0, out_data/out_rd/out_wen are driven 0.
- Latency: an accepted item appears on out_* at the next edge when the FIFO is empty. Minimum latency is 1 cycle; throughput is 1 item/cycle with out_ready held high.
- CC update:
  - On accept with in_setcc=1, CC <= {in_z, in_v, in_n} at that edge.
  - CC updates at accept, not at pop.
  - in_setcc=0 leaves CC unchanged.
  - No accept means no CC change, whatever in_setcc is.
- cond_true is combinational from registered CC only. There is no bypass of the in_* flags; a branch that depends on the immediately preceding op sees the new CC one cycle after accept.
- cond_sel encoding:
  - 0 always
  - 1 EQ (z)
  - 2 NE (!z)
  - 3 LT (n^v)
  - 4 GE (!(n^v))
  - 5 MI (n)
  - 6 VS (v)
  - 7 never
- Upstream must hold in_* stable while in_valid & !in_ready. The stage does not check this.

Decomposition:
- Shared defines header, alongside the ALU op defines:
  - COND_* encodings (0-7).
  - DATA_W/RD_W defaults.
- Sub-module cond_eval: combinational, inputs CC + cond_sel, output cond_true. The branch unit reuses it.
- FIFO storage and pointers stay inline.

Test Plan:
- Reset: drive rst_n=0 mid-stream with count=2 -> out_valid=0, CC=000, in_ready=0 immediately; in_ready=1 one edge after release.
- NAND result:
  - Stimulus: accept in_data=0xFFFE, z=0, v=0, n=1, rd=3, wen=1, setcc=1.
  - Response: next cycle out_valid=1, out_data=0xFFFE, out_rd=3, cc_n=1.
  - cond_sel=5 -> 1; cond_sel=1 -> 0.
- Zero result: accept in_data=0x0000, z=1, setcc=1 -> cc_z=1, cc_n=0; cond_sel=1 -> 1; cond_sel=2 -> 0.
- Full/backpressure:
  - Hold out_ready=0 and push 0x1111 then 0x2222 -> in_ready=0 after the second accept; a third in_valid is not accepted.
  - Raise out_ready -> pops 0x1111 then 0x2222 in order; in_ready returns to 1.
- Simultaneous accept and pop at count=1, streaming 0xA000..0xA00F -> count stays 1, order preserved, 16 items out in 16 cycles.
- CC gating:
  - Accept with setcc=0 and flags z=1 v=1 n=1 -> CC unchanged.
  - in_valid=0 with setcc=1 -> CC unchanged.
  - LT check: CC n=1, v=1 -> cond_sel=3 gives 0, cond_sel=4 gives 1.
